// File: rtl/dmem_arbiter.sv
// Data memory arbiter: serialises core and debug accesses onto one single-ported memory,
// absorbs a fixed read latency and stalls the core while its access is in flight.
module dmem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned PRIO    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);
    localparam int unsigned CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);
    localparam logic        RR       = (PRIO == 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_d;   // most recent grant went to the debug port
    logic          own_d;    // current transaction belongs to the debug port
    logic          lat_we;
    logic          gnt_c, gnt_d, fin;

    assign c_stall = c_req & ~c_done;

    // Next-state, grant and completion decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_c     = 1'b0;
        gnt_d     = 1'b0;
        fin       = 1'b0;
        case (state)
            S_IDLE: begin
                if (c_req || d_req) begin
                    if (d_req && (!c_req || (RR && !last_d))) gnt_d = 1'b1;
                    else                                      gnt_c = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = LAT_INIT;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    fin       = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, payload latch and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            last_d  <= 1'b1;
            own_d   <= 1'b0;
            lat_we  <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_rdata <= '0;
            d_rdata <= '0;
            c_done  <= 1'b0;
            d_done  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            m_en   <= gnt_c | gnt_d;
            m_we   <= (gnt_c & c_we) | (gnt_d & d_we);
            c_done <= fin & ~own_d;
            d_done <= fin & own_d;
            busy   <= (state_nxt != S_IDLE);
            if (gnt_c || gnt_d) begin
                own_d   <= gnt_d;
                last_d  <= gnt_d;
                lat_we  <= gnt_d ? d_we : c_we;
                m_addr  <= gnt_d ? d_addr : c_addr;
                m_wdata <= gnt_d ? d_wdata : c_wdata;
            end
            if (fin && !lat_we) begin
                if (own_d) d_rdata <= m_rdata;
                else       c_rdata <= m_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1/round-robin and MEM_LAT=3/core priority)
// with latency-accurate memory models, directed scenarios and a randomized scoreboard.
module tb_dmem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst [2];
    logic          c_req [2], c_we [2], d_req [2], d_we [2];
    logic [AW-1:0] c_addr [2], d_addr [2], m_addr [2];
    logic [DW-1:0] c_wdata [2], d_wdata [2], c_rdata [2], d_rdata [2];
    logic [DW-1:0] m_wdata [2], m_rdata [2];
    logic          c_done [2], c_stall [2], d_done [2], m_en [2], m_we [2], busy [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .PRIO(0)) dut0 (
        .clk(clk), .rst(rst[0]),
        .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
        .c_rdata(c_rdata[0]), .c_done(c_done[0]), .c_stall(c_stall[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_done(d_done[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .busy(busy[0])
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .PRIO(1)) dut1 (
        .clk(clk), .rst(rst[1]),
        .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
        .c_rdata(c_rdata[1]), .c_done(c_done[1]), .c_stall(c_stall[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_done(d_done[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .busy(busy[1])
    );

    // Memory models: read data appears MEM_LAT edges after the m_en sample, junk otherwise
    logic [DW-1:0] mem [2][256];
    logic [DW-1:0] ref_mem [2][256];
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1 [3];
    logic          pl_en = 1'b0;
    int            pl_k  = 0;
    logic [7:0]    pl_a  = 8'h0;
    logic [DW-1:0] pl_d  = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_k][pl_a] <= pl_d;
        for (int k = 0; k < 2; k++)
            if (m_en[k] && m_we[k]) mem[k][m_addr[k][7:0]] <= m_wdata[k];
        pipe0    <= (m_en[0] && !m_we[0]) ? mem[0][m_addr[0][7:0]] : JUNK;
        pipe1[0] <= (m_en[1] && !m_we[1]) ? mem[1][m_addr[1][7:0]] : JUNK;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign m_rdata[0] = pipe0;
    assign m_rdata[1] = pipe1[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-port history, indexed by cycle, for checking issue timing against completions
    logic          men_h [2][64];
    logic          mwe_h [2][64];
    logic [AW-1:0] madr_h [2][64];
    logic [DW-1:0] mwd_h [2][64];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            men_h[k][cyc % 64]  <= m_en[k];
            mwe_h[k][cyc % 64]  <= m_we[k];
            madr_h[k][cyc % 64] <= m_addr[k];
            mwd_h[k][cyc % 64]  <= m_wdata[k];
        end
    end

    task automatic preload(input int k, input logic [7:0] a, input logic [DW-1:0] d);
        pl_k = k; pl_a = a; pl_d = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[k][a] = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({c_done[k], d_done[k], m_en[k], m_we[k], busy[k], c_stall[k]} !== 6'b0) begin
                fails++;
                $display("FAIL reset_ctrl[%0d]: got %b required 000000", k,
                         {c_done[k], d_done[k], m_en[k], m_we[k], busy[k], c_stall[k]});
            end
            tests++;
            if (m_addr[k] !== '0 || m_wdata[k] !== '0 || c_rdata[k] !== '0 || d_rdata[k] !== '0) begin
                fails++;
                $display("FAIL reset_data[%0d]: got %h %h %h %h required all zero", k,
                         m_addr[k], m_wdata[k], c_rdata[k], d_rdata[k]);
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_core_load();
        preload(0, 8'h10, 32'hDEAD_BEEF);
        c_we[0] = 1'b0; c_addr[0] = 32'h10; c_req[0] = 1'b1;
        #1;
        tests++;
        if (c_stall[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL load_t0: stall=%b busy=%b required 1 0", c_stall[0], busy[0]);
        end
        @(negedge clk);
        tests++;
        if (m_en[0] !== 1'b1 || m_we[0] !== 1'b0 || m_addr[0] !== 32'h10 || busy[0] !== 1'b1 || c_stall[0] !== 1'b1) begin
            fails++;
            $display("FAIL load_issue: en=%b we=%b addr=%h busy=%b stall=%b required 1 0 10 1 1",
                     m_en[0], m_we[0], m_addr[0], busy[0], c_stall[0]);
        end
        @(negedge clk);
        tests++;
        if (m_en[0] !== 1'b0 || c_done[0] !== 1'b0 || c_stall[0] !== 1'b1) begin
            fails++; $display("FAIL load_wait: en=%b done=%b stall=%b required 0 0 1", m_en[0], c_done[0], c_stall[0]);
        end
        @(negedge clk);
        tests++;
        if (c_done[0] !== 1'b1 || c_rdata[0] !== 32'hDEAD_BEEF || c_stall[0] !== 1'b0 || d_done[0] !== 1'b0) begin
            fails++;
            $display("FAIL load_done: done=%b rdata=%h stall=%b d_done=%b required 1 deadbeef 0 0",
                     c_done[0], c_rdata[0], c_stall[0], d_done[0]);
        end
        c_req[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (c_done[0] !== 1'b0 || busy[0] !== 1'b0 || c_rdata[0] !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL load_after: done=%b busy=%b rdata=%h required 0 0 deadbeef", c_done[0], busy[0], c_rdata[0]);
        end
    endtask

    task automatic test_core_store();
        c_we[0] = 1'b1; c_addr[0] = 32'h20; c_wdata[0] = 32'h1234; c_req[0] = 1'b1;
        @(negedge clk);
        tests++;
        if (m_en[0] !== 1'b1 || m_we[0] !== 1'b1 || m_addr[0] !== 32'h20 || m_wdata[0] !== 32'h1234) begin
            fails++;
            $display("FAIL store_issue: en=%b we=%b addr=%h data=%h required 1 1 20 1234",
                     m_en[0], m_we[0], m_addr[0], m_wdata[0]);
        end
        @(negedge clk);
        tests++;
        if (m_we[0] !== 1'b0 || c_done[0] !== 1'b0) begin
            fails++; $display("FAIL store_wait: we=%b done=%b required 0 0", m_we[0], c_done[0]);
        end
        @(negedge clk);
        tests++;
        if (c_done[0] !== 1'b1 || c_rdata[0] !== 32'hDEAD_BEEF || mem[0][8'h20] !== 32'h1234) begin
            fails++;
            $display("FAIL store_done: done=%b rdata=%h mem=%h required 1 deadbeef 1234",
                     c_done[0], c_rdata[0], mem[0][8'h20]);
        end
        c_req[0] = 1'b0; c_we[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conflict_rr();
        logic ec, ed;
        preload(0, 8'h30, 32'h0BAD_F00D);
        c_we[0] = 1'b0; c_addr[0] = 32'h10; d_we[0] = 1'b0; d_addr[0] = 32'h30;
        c_req[0] = 1'b1; d_req[0] = 1'b1; rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            ec = (n % 4 == 3) && ((n / 4) % 2 == 0);
            ed = (n % 4 == 3) && ((n / 4) % 2 == 1);
            tests++;
            if (c_done[0] !== ec || d_done[0] !== ed) begin
                fails++;
                $display("FAIL rr_done n=%0d: c=%b d=%b required %b %b", n, c_done[0], d_done[0], ec, ed);
            end
            if (n == 7) begin
                tests++;
                if (d_rdata[0] !== 32'h0BAD_F00D || c_rdata[0] !== 32'hDEAD_BEEF) begin
                    fails++;
                    $display("FAIL rr_data: d=%h c=%h required 0badf00d deadbeef", d_rdata[0], c_rdata[0]);
                end
            end
        end
        c_req[0] = 1'b0; d_req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conflict_prio();
        logic ec;
        preload(1, 8'h10, 32'h600D_CAFE);
        c_we[1] = 1'b0; c_addr[1] = 32'h10; d_we[1] = 1'b0; d_addr[1] = 32'h10;
        c_req[1] = 1'b1; d_req[1] = 1'b1; rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        for (int n = 1; n <= 23; n++) begin
            @(negedge clk);
            ec = (n % 6 == 5);
            tests++;
            if (c_done[1] !== ec || d_done[1] !== 1'b0) begin
                fails++;
                $display("FAIL prio_done n=%0d: c=%b d=%b required %b 0", n, c_done[1], d_done[1], ec);
            end
        end
        tests++;
        if (c_rdata[1] !== 32'h600D_CAFE) begin
            fails++; $display("FAIL prio_data: got %h required 600dcafe", c_rdata[1]);
        end
        c_req[1] = 1'b0; d_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_debug_lat3();
        preload(1, 8'h04, 32'hA5A5_A5A5);
        d_we[1] = 1'b0; d_addr[1] = 32'h4; d_wdata[1] = '0; d_req[1] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 2) begin
                d_we[1] = 1'b1; d_addr[1] = 32'h8; d_wdata[1] = 32'hFFFF_FFFF;
            end
            tests++;
            if (d_done[1] !== (n == 5) || m_en[1] !== (n == 1) || m_addr[1] !== 32'h4 || c_done[1] !== 1'b0) begin
                fails++;
                $display("FAIL lat3 n=%0d: d_done=%b en=%b addr=%h c_done=%b", n, d_done[1], m_en[1], m_addr[1], c_done[1]);
            end
            if (n == 5) begin
                tests++;
                if (d_rdata[1] !== 32'hA5A5_A5A5) begin
                    fails++; $display("FAIL lat3_data: got %h required a5a5a5a5", d_rdata[1]);
                end
                d_req[1] = 1'b0; d_we[1] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_wait();
        preload(1, 8'h40, 32'h1357_9BDF);
        c_we[1] = 1'b0; c_addr[1] = 32'h40; c_req[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst[1] = 1'b1; c_req[1] = 1'b0;
        @(negedge clk);
        tests++;
        if ({c_done[1], d_done[1], m_en[1], m_we[1], busy[1], c_stall[1]} !== 6'b0 ||
            m_addr[1] !== '0 || m_wdata[1] !== '0 || c_rdata[1] !== '0 || d_rdata[1] !== '0) begin
            fails++;
            $display("FAIL rst_wait: ctrl=%b addr=%h wd=%h crd=%h drd=%h required all zero",
                     {c_done[1], d_done[1], m_en[1], m_we[1], busy[1], c_stall[1]},
                     m_addr[1], m_wdata[1], c_rdata[1], d_rdata[1]);
        end
        rst[1] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            tests++;
            if (c_done[1] !== 1'b0 || d_done[1] !== 1'b0 || busy[1] !== 1'b0) begin
                fails++; $display("FAIL rst_no_retry n=%0d: c=%b d=%b busy=%b required 0 0 0", n, c_done[1], d_done[1], busy[1]);
            end
        end
        c_req[1] = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            tests++;
            if (c_done[1] !== (n == 5)) begin
                fails++; $display("FAIL rst_fresh n=%0d: done=%b required %b", n, c_done[1], (n == 5));
            end
        end
        tests++;
        if (c_rdata[1] !== 32'h1357_9BDF) begin
            fails++; $display("FAIL rst_fresh_data: got %h required 13579bdf", c_rdata[1]);
        end
        c_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic requester(input int k, input bit dbg);
        int lat, waited, slot, a;
        logic we, dn, other;
        logic [DW-1:0] wd, rd;
        bit got;
        lat = (k == 0) ? 1 : 3;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we = 1'($urandom_range(0, 1)); a = int'($urandom_range(0, 15)); wd = $urandom;
            if (dbg) begin
                d_we[k] = we; d_addr[k] = AW'(a); d_wdata[k] = wd; d_req[k] = 1'b1;
            end else begin
                c_we[k] = we; c_addr[k] = AW'(a); c_wdata[k] = wd; c_req[k] = 1'b1;
            end
            got = 1'b0; waited = 0;
            while (!got && waited < 100) begin
                @(negedge clk);
                waited++;
                dn = dbg ? d_done[k] : c_done[k];
                if (dn) got = 1'b1;
                else if (!dbg) begin
                    tests++;
                    if (c_stall[k] !== 1'b1) begin
                        fails++; $display("FAIL rnd_stall[%0d]: got %b required 1", k, c_stall[k]);
                    end
                end
            end
            tests++;
            if (!got) begin
                fails++; $display("FAIL rnd_timeout[%0d] dbg=%0d: no done after %0d cycles", k, dbg, waited);
            end else begin
                other = dbg ? c_done[k] : d_done[k];
                rd    = dbg ? d_rdata[k] : c_rdata[k];
                slot  = (cyc - lat - 1) % 64;
                if (other !== 1'b0 || waited < lat + 2) begin
                    fails++; $display("FAIL rnd_done[%0d] dbg=%0d: other=%b wait=%0d min=%0d", k, dbg, other, waited, lat + 2);
                end
                tests++;
                if (men_h[k][slot] !== 1'b1 || mwe_h[k][slot] !== we || madr_h[k][slot] !== AW'(a) ||
                    (we && mwd_h[k][slot] !== wd)) begin
                    fails++;
                    $display("FAIL rnd_issue[%0d] dbg=%0d: en=%b we=%b addr=%h wd=%h required 1 %b %h %h",
                             k, dbg, men_h[k][slot], mwe_h[k][slot], madr_h[k][slot], mwd_h[k][slot], we, AW'(a), wd);
                end
                if (we) ref_mem[k][a] = wd;
                else begin
                    tests++;
                    if (rd !== ref_mem[k][a]) begin
                        fails++; $display("FAIL rnd_load[%0d] dbg=%0d addr=%0d: got %h required %h", k, dbg, a, rd, ref_mem[k][a]);
                    end
                end
            end
            if (dbg) d_req[k] = 1'b0;
            else     c_req[k] = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 16; a++)
            for (int k = 0; k < 2; k++)
                preload(k, 8'(a), $urandom);
        fork
            requester(0, 1'b0);
            requester(0, 1'b1);
            requester(1, 1'b0);
            requester(1, 1'b1);
        join
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_core_store();
        test_conflict_rr();
        test_conflict_prio();
        test_debug_lat3();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
